dm_arbiter: RTL and testbench

- Shares the single-port data memory (dm) between the SPU and a host port, which is used for program data load, result readback and debug.
- Sits between the SPU's dm_addr/dm_rd/dm_wr/dm_w_data outputs and the physical dm.
- The SPU has priority. The host is protected from starvation by a wait-limit counter, and is allowed a bounded burst once it owns the memory.
- Read data from dm's 1-cycle synchronous read is returned with a per-requester valid strobe.

---
 rtl/spu_pkg.sv | 6 +
 rtl/dm_arbiter.sv | 67 ++++++
 tb/tb_dm_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spu_pkg.sv
// spu_pkg: shared dm geometry and arbiter owner encoding
package spu_pkg;
  localparam int DM_AW = 8;
  localparam int DM_DW = 16;
  typedef enum logic [1:0] {IDLE, SPU, HOST} owner_t;
endpackage

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port dm between the SPU (priority) and a host port with burst and anti-starvation limits
module dm_arbiter
  import spu_pkg::*;
#(
  parameter int AW = DM_AW,
  parameter int DW = DM_DW,
  parameter int HOST_BURST = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] spu_addr,
  input  logic          spu_rd,
  input  logic          spu_wr,
  input  logic [DW-1:0] spu_w_data,
  output logic          spu_wait,
  output logic          spu_r_valid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_w_data,
  output logic          host_gnt,
  output logic          host_r_valid,
  output logic [AW-1:0] dm_addr,
  output logic          dm_rd,
  output logic          dm_wr,
  output logic [DW-1:0] dm_w_data,
  input  logic [DW-1:0] dm_r_data
);
  localparam int HW = $clog2(HOST_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [HW-1:0] HB = HW'(HOST_BURST);
  localparam logic [SW-1:0] SL = SW'(STARVE_LIMIT);
  owner_t owner;
  logic [HW-1:0] host_cnt;
  logic [SW-1:0] starve_cnt;
  logic spu_req, spu_win, host_win, spu_rv, host_rv;
  always_comb begin
    spu_req = spu_rd | spu_wr;
    host_win = ~rst & host_req & (~spu_req | (owner == HOST && host_cnt < HB) | (starve_cnt == SL));
    spu_win = ~rst & spu_req & ~host_win;
    host_gnt = host_win;
    spu_wait = spu_req & ~spu_win;
    dm_addr = host_win ? host_addr : spu_win ? spu_addr : '0;
    dm_w_data = host_win ? host_w_data : spu_win ? spu_w_data : '0;
    dm_wr = (host_win & host_we) | (spu_win & spu_wr);
    dm_rd = (host_win & ~host_we) | (spu_win & spu_rd & ~spu_wr);
    // a read return pending across a reset edge is suppressed
    spu_r_valid = spu_rv & ~rst;
    host_r_valid = host_rv & ~rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= IDLE;
      host_cnt <= '0;
      starve_cnt <= '0;
      spu_rv <= 1'b0;
      host_rv <= 1'b0;
    end else begin
      owner <= host_win ? HOST : spu_win ? SPU : IDLE;
      host_cnt <= host_win ? host_cnt + HW'(spu_req) : '0;
      starve_cnt <= (host_req & ~host_win) ? ((starve_cnt == SL) ? SL : starve_cnt + 1'b1) : '0;
      spu_rv <= spu_win & spu_rd & ~spu_wr;
      host_rv <= host_win & ~host_we;
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed vectors plus a per-cycle behavioural model check of dm_arbiter
module tb_dm_arbiter;
  localparam int HB = 4;
  localparam int SL = 8;
  logic clk = 0, rst = 1;
  logic [7:0] spu_addr = 0, host_addr = 0, dm_addr;
  logic spu_rd = 0, spu_wr = 0, spu_wait, spu_r_valid;
  logic host_req = 0, host_we = 0, host_gnt, host_r_valid, dm_rd, dm_wr;
  logic [15:0] spu_w_data = 0, host_w_data = 0, dm_w_data, dm_r_data;
  logic [15:0] mem [256];
  int n_vec = 0, n_err = 0;
  bit m_last_host = 0, m_srv = 0, m_hrv = 0;
  int m_streak = 0, m_wait = 0;

  dm_arbiter #(.AW(8), .DW(16), .HOST_BURST(HB), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .spu_addr(spu_addr), .spu_rd(spu_rd), .spu_wr(spu_wr), .spu_w_data(spu_w_data),
    .spu_wait(spu_wait), .spu_r_valid(spu_r_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_w_data(host_w_data),
    .host_gnt(host_gnt), .host_r_valid(host_r_valid),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_w_data(dm_w_data), .dm_r_data(dm_r_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dm_wr) mem[dm_addr] <= dm_w_data;
    dm_r_data <= mem[dm_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: host wins when alone, while inside its burst allowance, or once it has waited SL cycles.
  always @(negedge clk) begin
    bit sreq, hw, sw, erd, ewr;
    logic [7:0] ea;
    logic [15:0] ed;
    sreq = spu_rd | spu_wr;
    hw = !rst && host_req && (!sreq || (m_last_host && m_streak < HB) || m_wait == SL);
    sw = !rst && sreq && !hw;
    ea = hw ? host_addr : sw ? spu_addr : 8'h0;
    ed = hw ? host_w_data : sw ? spu_w_data : 16'h0;
    ewr = (hw && host_we) || (sw && spu_wr);
    erd = (hw && !host_we) || (sw && spu_rd && !spu_wr);
    chk("cycle", {34'b0, host_gnt, spu_wait, dm_rd, dm_wr, spu_r_valid, host_r_valid, dm_addr, dm_w_data},
        {34'b0, hw, sreq && !sw, erd, ewr, m_srv && !rst, m_hrv && !rst, ea, ed});
    if (rst) begin
      m_last_host = 0; m_streak = 0; m_wait = 0; m_srv = 0; m_hrv = 0;
    end else begin
      m_last_host = hw;
      m_streak = hw ? m_streak + int'(sreq) : 0;
      m_wait = (host_req && !hw) ? ((m_wait + 1 > SL) ? SL : m_wait + 1) : 0;
      m_srv = sw && spu_rd && !spu_wr;
      m_hrv = hw && !host_we;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h10] = 16'hBEEF;
    cyc(2);
    spu_rd = 1;
    #1;
    chk("rst_spu_wait", spu_wait, 1);
    chk("rst_no_rd", dm_rd, 0);
    cyc();
    rst = 0; spu_rd = 0;
    cyc();
    spu_rd = 1; spu_addr = 8'h10;
    #1;
    chk("spu_rd_strobe", {dm_rd, spu_wait, dm_addr}, {1'b1, 1'b0, 8'h10});
    cyc();
    spu_rd = 0;
    #1;
    chk("spu_r_valid", {spu_r_valid, host_r_valid, dm_r_data}, {1'b1, 1'b0, 16'hBEEF});
    host_req = 1; host_we = 1; host_addr = 8'h20; host_w_data = 16'h1234;
    #1;
    chk("host_wr", {host_gnt, dm_wr, dm_addr, dm_w_data}, {1'b1, 1'b1, 8'h20, 16'h1234});
    cyc();
    host_we = 0; host_addr = 8'h21; spu_rd = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("burst_%0d", i), {host_gnt, spu_wait}, (i < 4) ? 2'b11 : 2'b00);
      cyc();
    end
    host_req = 0;
    cyc(3);
    host_req = 1;
    for (int i = 0; i < 13; i++) begin
      #1;
      chk($sformatf("starve_%0d", i), host_gnt, (i >= 8 && i <= 11));
      cyc();
    end
    host_req = 0;
    cyc(2);
    host_req = 1;
    cyc(5);
    host_req = 0;
    cyc();
    host_req = 1;
    cyc(7);
    chk("restart_wait7", host_gnt, 0);
    cyc();
    chk("restart_wait8", host_gnt, 1);
    cyc();
    host_req = 0; spu_rd = 1; spu_wr = 1; spu_addr = 8'h30; spu_w_data = 16'h5555;
    #1;
    chk("rw_both", {dm_wr, dm_rd}, 2'b10);
    cyc();
    spu_rd = 0; spu_wr = 0;
    #1;
    chk("rw_no_valid", spu_r_valid, 0);
    host_req = 1; host_we = 0; host_addr = 8'h30;
    #1;
    chk("host_rd_gnt", host_gnt, 1);
    cyc();
    rst = 1; host_req = 0;
    #1;
    chk("rst_hrv", host_r_valid, 0);
    cyc();
    chk("rst_hrv2", host_r_valid, 0);
    rst = 0; spu_rd = 1; host_req = 1;
    #1;
    chk("post_rst_spu", {host_gnt, spu_wait, host_r_valid}, 3'b000);
    cyc();
    for (int i = 0; i < 60; i++) begin
      spu_rd = 1'($urandom_range(0, 1));
      spu_wr = ($urandom_range(0, 3) == 0);
      spu_addr = 8'($urandom);
      spu_w_data = 16'($urandom);
      if (!host_req || host_gnt) begin
        host_req = ($urandom_range(0, 2) != 0);
        host_we = 1'($urandom_range(0, 1));
        host_addr = 8'($urandom);
        host_w_data = 16'($urandom);
      end
      rst = ($urandom_range(0, 29) == 0);
      cyc();
    end
    rst = 0; spu_rd = 0; spu_wr = 0; host_req = 0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
